// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch (T0..T2), decode/execute (T3..T5), halt.
// Optional macro SEQ_MEMWAIT_EN stretches T1 until MemReady is seen.
module control_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Run,
  input  logic [31:0]           IR,
  input  logic                  MemReady,
  output logic                  PCout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  ZLOout,
  output logic                  PCin,
  output logic                  IncrementPC,
  output logic                  Read,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Yin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Halted,
  output logic [2:0]            Step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
    S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_HALT = 3'd7
  } state_e;

  typedef struct packed {
    logic pc_out, mar_in, z_in, zlo_out, pc_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in;
  } ctrl_t;

  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_NOP  = 5'b11110;

  state_e                  state_q, state_d;
  logic [4:0]              opc_q, opc_d;
  logic [3:0]              ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0]     rout_q, rout_d, rin_q, rin_d;
  logic [ALU_CTRL_W-1:0]   alu_q, alu_d;
  logic                    busy_q, busy_d, done_q, done_d, halted_q, halted_d;
  logic                    t1_exit;
  logic                    special_op;
  logic                    unused_inputs;

`ifdef SEQ_MEMWAIT_EN
  assign t1_exit = MemReady;
`else
  assign t1_exit = 1'b1;
`endif

  assign unused_inputs = ^{IR[14:0], MemReady};

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) reg_sel[i] = 1'b1;
    end
  endfunction

  // IR is loaded during T2, so its fields are captured on entry to T3 and
  // every decode-dependent control in T3..T5 comes straight from flops.
  always_comb begin
    opc_d = opc_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    rc_d  = rc_q;
    if (state_q == S_T2) {opc_d, ra_d, rb_d, rc_d} = IR[31:15];
  end

  assign special_op = (opc_d == OP_HALT) || (opc_d == OP_NOP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (t1_exit) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (opc_q == OP_HALT)     state_d = S_HALT;
        else if (opc_q == OP_NOP) state_d = S_T5;
        else                      state_d = S_T4;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = Run ? S_T0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    ctrl_d   = '0;
    rout_d   = '0;
    rin_d    = '0;
    alu_d    = '0;
    done_d   = 1'b0;
    halted_d = (state_d == S_HALT);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    case (state_d)
      S_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.z_in   = 1'b1;
      end
      S_T1: begin
        ctrl_d.zlo_out = 1'b1;
        ctrl_d.pc_in   = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
        ctrl_d.read    = 1'b1;
        ctrl_d.mdr_in  = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        if (!special_op) begin
          rout_d      = reg_sel(rb_d);
          ctrl_d.y_in = 1'b1;
        end
      end
      S_T4: begin
        rout_d      = reg_sel(rc_d);
        ctrl_d.z_in = 1'b1;
        alu_d       = ALU_CTRL_W'(opc_d);
      end
      S_T5: begin
        done_d = 1'b1;
        if (opc_d != OP_NOP) begin
          ctrl_d.zlo_out = 1'b1;
          rin_d          = reg_sel(ra_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      ctrl_q   <= '0;
      rout_q   <= '0;
      rin_q    <= '0;
      alu_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      ctrl_q   <= ctrl_d;
      rout_q   <= rout_d;
      rin_q    <= rin_d;
      alu_q    <= alu_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign PCout       = ctrl_q.pc_out;
  assign MARin       = ctrl_q.mar_in;
  assign Zin         = ctrl_q.z_in;
  assign ZLOout      = ctrl_q.zlo_out;
  assign PCin        = ctrl_q.pc_in;
  assign IncrementPC = ctrl_q.inc_pc;
  assign Read        = ctrl_q.read;
  assign MDRin       = ctrl_q.mdr_in;
  assign MDRout      = ctrl_q.mdr_out;
  assign IRin        = ctrl_q.ir_in;
  assign Yin         = ctrl_q.y_in;
  assign Rout        = rout_q;
  assign Rin         = rin_q;
  assign ALUControl  = alu_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Halted      = halted_q;
  assign Step        = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step-level reference model checked every cycle
// against a 16-register and an 8-register instance, plus hand-computed pins.
module tb_control_sequencer;

`ifdef SEQ_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Clear, Run, MemReady;
  logic [31:0] IR;

  logic a_PCout, a_MARin, a_Zin, a_ZLOout, a_PCin, a_IncrementPC, a_Read, a_MDRin, a_MDRout, a_IRin, a_Yin;
  logic a_Busy, a_Done, a_Halted;
  logic [15:0] a_Rout, a_Rin;
  logic [4:0]  a_ALUControl;
  logic [2:0]  a_Step;

  logic b_PCout, b_MARin, b_Zin, b_ZLOout, b_PCin, b_IncrementPC, b_Read, b_MDRin, b_MDRout, b_IRin, b_Yin;
  logic b_Busy, b_Done, b_Halted;
  logic [7:0]  b_Rout, b_Rin;
  logic [4:0]  b_ALUControl;
  logic [2:0]  b_Step;

  control_sequencer #(.NUM_REGS(16), .ALU_CTRL_W(5)) dut16 (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemReady(MemReady),
    .PCout(a_PCout), .MARin(a_MARin), .Zin(a_Zin), .ZLOout(a_ZLOout), .PCin(a_PCin),
    .IncrementPC(a_IncrementPC), .Read(a_Read), .MDRin(a_MDRin), .MDRout(a_MDRout),
    .IRin(a_IRin), .Yin(a_Yin), .Rout(a_Rout), .Rin(a_Rin), .ALUControl(a_ALUControl),
    .Busy(a_Busy), .Done(a_Done), .Halted(a_Halted), .Step(a_Step));

  control_sequencer #(.NUM_REGS(8), .ALU_CTRL_W(5)) dut8 (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemReady(MemReady),
    .PCout(b_PCout), .MARin(b_MARin), .Zin(b_Zin), .ZLOout(b_ZLOout), .PCin(b_PCin),
    .IncrementPC(b_IncrementPC), .Read(b_Read), .MDRin(b_MDRin), .MDRout(b_MDRout),
    .IRin(b_IRin), .Yin(b_Yin), .Rout(b_Rout), .Rin(b_Rin), .ALUControl(b_ALUControl),
    .Busy(b_Busy), .Done(b_Done), .Halted(b_Halted), .Step(b_Step));

  always #5 Clock = ~Clock;

  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;

  // Reference model: step number (0 idle, 1..6 = T0..T5, 7 halt) and the IR seen entering T3.
  int          m_step = 0;
  logic [31:0] m_ir   = '0;

  always @(posedge Clock) begin
    if (Clear)                                     m_step = 0;
    else if (m_step == 0 || m_step == 6)           m_step = Run ? 1 : 0;
    else if (m_step == 2 && MEMWAIT && !MemReady)  m_step = 2;
    else if (m_step == 3) begin m_ir = IR;         m_step = 4; end
    else if (m_step == 4)
      m_step = (m_ir[31:27] == 5'd31) ? 7 : (m_ir[31:27] == 5'd30) ? 6 : 5;
    else if (m_step != 7)                          m_step = m_step + 1;
  end

  function automatic logic [15:0] sel(input logic [3:0] idx, input int nregs);
    logic [15:0] one;
    one = 16'h0001;
    return (int'(idx) < nregs) ? (one << idx) : 16'h0000;
  endfunction

  // {Step, Busy, Done, Halted, 11 controls, ALUControl, Rout, Rin}
  function automatic logic [53:0] exp_vec(input int step, input logic [31:0] ir, input int nregs);
    logic [4:0]  op;
    logic [10:0] c;
    logic [4:0]  alu;
    logic [15:0] ro, ri;
    op = ir[31:27]; c = '0; alu = '0; ro = '0; ri = '0;
    case (step)
      1: c = 11'b11100000000;
      2: c = 11'b00011111000;
      3: c = 11'b00000000110;
      4: if (op < 5'd30) begin c = 11'b00000000001; ro = sel(ir[22:19], nregs); end
      5: begin c = 11'b00100000000; ro = sel(ir[18:15], nregs); alu = op; end
      6: if (op != 5'd30) begin c = 11'b00010000000; ri = sel(ir[26:23], nregs); end
      default: ;
    endcase
    return {3'(step), (step >= 1 && step <= 6), (step == 6), (step == 7), c, alu, ro, ri};
  endfunction

  logic [53:0] a_vec, b_vec;
  assign a_vec = {a_Step, a_Busy, a_Done, a_Halted, a_PCout, a_MARin, a_Zin, a_ZLOout, a_PCin,
                  a_IncrementPC, a_Read, a_MDRin, a_MDRout, a_IRin, a_Yin, a_ALUControl, a_Rout, a_Rin};
  assign b_vec = {b_Step, b_Busy, b_Done, b_Halted, b_PCout, b_MARin, b_Zin, b_ZLOout, b_PCin,
                  b_IncrementPC, b_Read, b_MDRin, b_MDRout, b_IRin, b_Yin, b_ALUControl,
                  8'h00, b_Rout, 8'h00, b_Rin};

  always @(posedge Clock) begin
    #1;
    if (chk_en) begin
      logic [53:0] e16, e8;
      e16 = exp_vec(m_step, m_ir, 16);
      e8  = exp_vec(m_step, m_ir, 8);
      tests++;
      if (a_vec !== e16) begin
        fails++;
        $display("FAIL model16 t=%0t: got %014h expected %014h", $time, a_vec, e16);
      end
      tests++;
      if (b_vec !== e8) begin
        fails++;
        $display("FAIL model8 t=%0t: got %014h expected %014h", $time, b_vec, e8);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  int done_cnt, t1_cnt, read_cnt;
  logic [2:0] seq [13];

  initial begin
    Clear = 1'b1; Run = 1'b0; IR = '0; MemReady = 1'b1;
    tick(); tick();
    Clear = 1'b0; chk_en = 1'b1;
    chk("reset_step", 32'(a_Step), 0);
    chk("reset_busy", 32'(a_Busy), 0);

    // opcode 3, Ra=3, Rb=2, Rc=3
    IR = 32'h1991_8000; Run = 1'b1;
    tick(); Run = 1'b0;
    chk("t0_step", 32'(a_Step), 1);
    chk("t0_pcout", 32'(a_PCout), 1);
    tick(); chk("t1_read", 32'(a_Read), 1);
    tick(); chk("t2_irin", 32'(a_IRin), 1);
    tick(); chk("t3_rout", 32'(a_Rout), 32'h0004);
    chk("t3_yin", 32'(a_Yin), 1);
    tick(); chk("t4_rout", 32'(a_Rout), 32'h0008);
    chk("t4_alu", 32'(a_ALUControl), 3);
    tick(); chk("t5_rin", 32'(a_Rin), 32'h0008);
    chk("t5_done", 32'(a_Done), 1);
    tick(); chk("after_idle", 32'(a_Step), 0);

    // opcode 5, Ra=7, Rb=12, Rc=1, Run held across two instructions
    IR = 32'h2BE0_8000; Run = 1'b1; done_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      seq[i] = a_Step;
      done_cnt += int'(a_Done);
      if (i == 3) begin
        chk("b2b_t3_rout16", 32'(a_Rout), 32'h1000);
        chk("b2b_t3_rout8", 32'(b_Rout), 0);
        chk("b2b_t3_yin8", 32'(b_Yin), 1);
      end
      if (i == 4) chk("b2b_t4_alu", 32'(a_ALUControl), 5);
      if (i == 6) Run = 1'b0;
    end
    chk("b2b_seq5", 32'(seq[5]), 6);
    chk("b2b_seq6", 32'(seq[6]), 1);
    chk("b2b_seq12", 32'(seq[12]), 0);
    chk("b2b_done_cnt", 32'(done_cnt), 2);

    // halt opcode
    IR = 32'hF800_0000; Run = 1'b1;
    tick(); Run = 1'b0;
    tick(); tick(); tick();
    chk("halt_t3_yin", 32'(a_Yin), 0);
    tick();
    chk("halt_step", 32'(a_Step), 7);
    chk("halt_flag", 32'(a_Halted), 1);
    for (int i = 0; i < 4; i++) begin Run = ~Run; tick(); end
    chk("halt_sticky", 32'(a_Step), 7);
    Run = 1'b0; Clear = 1'b1;
    tick(); Clear = 1'b0;
    chk("halt_clear_step", 32'(a_Step), 0);
    chk("halt_clear_flag", 32'(a_Halted), 0);

    // nop opcode with Ra=2
    IR = 32'hF100_0000; Run = 1'b1;
    tick(); Run = 1'b0;
    tick(); tick(); tick();
    chk("nop_t3_yin", 32'(a_Yin), 0);
    tick();
    chk("nop_t5_step", 32'(a_Step), 6);
    chk("nop_t5_done", 32'(a_Done), 1);
    chk("nop_t5_rin", 32'(a_Rin), 0);
    tick(); chk("nop_idle", 32'(a_Step), 0);

    // Clear during T4
    IR = 32'h1991_8000; Run = 1'b1;
    tick(); Run = 1'b0;
    tick(); tick(); tick(); tick();
    chk("clr_pre_step", 32'(a_Step), 5);
    Clear = 1'b1;
    tick(); Clear = 1'b0;
    chk("clr_step", 32'(a_Step), 0);
    chk("clr_zin", 32'(a_Zin), 0);
    chk("clr_rout", 32'(a_Rout), 0);
    chk("clr_alu", 32'(a_ALUControl), 0);

    // Clear wins over Run
    Run = 1'b1; Clear = 1'b1;
    tick();
    chk("clr_over_run", 32'(a_Step), 0);
    Clear = 1'b0; Run = 1'b0;
    tick();

    // MemReady low for the first three T1 cycles
    MemReady = 1'b0; Run = 1'b1; t1_cnt = 0; read_cnt = 0;
    tick(); Run = 1'b0;
    for (int k = 0; k < 14; k++) begin
      MemReady = (k >= 4);
      tick();
      if (a_Step == 3'd2) begin
        t1_cnt++;
        read_cnt += int'(a_Read);
      end
    end
    chk("mem_t1_len", 32'(t1_cnt), MEMWAIT ? 4 : 1);
    chk("mem_read_held", 32'(read_cnt), MEMWAIT ? 4 : 1);
    chk("mem_end_idle", 32'(a_Step), 0);
    MemReady = 1'b1;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
